// File: rtl/rot_sequencer_if.sv
// Handshake, operand and rotator-select bundle between a command source, the
// rotate sequencer and the external 4-bit combinational rotator.
interface rot_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_op;
    logic [1:0] in_amt;
    logic [3:0] rot_I;
    logic       rot_x;
    logic       rot_y;
    logic [3:0] rot_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    // Sequencer side
    modport slave (
        input  in_valid, in_data, in_op, in_amt, rot_b, out_ready,
        output in_ready, rot_I, rot_x, rot_y, out_valid, out_data, busy
    );

    // Command source / consumer / rotator side
    modport master (
        output in_valid, in_data, in_op, in_amt, rot_b, out_ready,
        input  in_ready, rot_I, rot_x, rot_y, out_valid, out_data, busy
    );
endinterface

// File: rtl/rot_sequencer.sv
// Splits a rotate/bit-reverse command into single-cycle passes through the
// fixed-select 4-bit rotator and presents the final word on a valid/ready port.
module rot_sequencer (
    input  logic            clk,
    input  logic            rst_n,
    rot_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, REV, STEP2, STEP1, DONE} state_t;

    state_t     r_state, w_nxt;
    logic [3:0] r_acc;
    logic [1:0] r_eff, w_eff_new;
    logic       r_in_ready, r_out_valid, r_busy, r_rot_x, r_rot_y;
    logic       w_accept;

    assign w_accept = bus.in_valid & r_in_ready;

    // Right rotates become left rotates by (4 - amt) mod 4, which 2-bit negation gives.
    always_comb begin
        w_eff_new = 2'd0;
        case (bus.in_op)
            2'b00, 2'b11: w_eff_new = bus.in_amt;
            2'b01:        w_eff_new = 2'd0 - bus.in_amt;
            default:      w_eff_new = 2'd0;
        endcase
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                if (bus.in_op[1])      w_nxt = REV;
                else if (w_eff_new[1]) w_nxt = STEP2;
                else if (w_eff_new[0]) w_nxt = STEP1;
                else                   w_nxt = DONE;
            end
            REV: begin
                if (r_eff[1])      w_nxt = STEP2;
                else if (r_eff[0]) w_nxt = STEP1;
                else               w_nxt = DONE;
            end
            STEP2:   w_nxt = r_eff[0] ? STEP1 : DONE;
            STEP1:   w_nxt = DONE;
            DONE:    if (bus.out_ready) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Handshake and select outputs are registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= 4'd0;
            r_eff       <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rot_x     <= 1'b0;
            r_rot_y     <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_in_ready  <= (w_nxt == IDLE);
            r_out_valid <= (w_nxt == DONE);
            r_busy      <= (w_nxt != IDLE);
            r_rot_x     <= (w_nxt == REV) || (w_nxt == STEP2);
            r_rot_y     <= (w_nxt == REV) || (w_nxt == STEP1);
            case (r_state)
                IDLE: if (w_accept) begin
                    r_acc <= bus.in_data;
                    r_eff <= w_eff_new;
                end
                REV, STEP2, STEP1: r_acc <= bus.rot_b;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.rot_x     = r_rot_x;
    assign bus.rot_y     = r_rot_y;
    assign bus.rot_I     = r_acc;
    assign bus.out_data  = r_acc;
endmodule

// File: tb/tb_rot_sequencer.sv
// Scoreboard bench for rot_sequencer with a behavioural rotator on rot_b.
module tb_rot_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [3:0] exp_q[$];

    rot_sequencer_if bus ();

    rot_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always_comb begin
        case ({bus.rot_x, bus.rot_y})
            2'b00:   bus.rot_b = bus.rot_I;
            2'b01:   bus.rot_b = {bus.rot_I[2:0], bus.rot_I[3]};
            2'b10:   bus.rot_b = {bus.rot_I[1:0], bus.rot_I[3:2]};
            default: bus.rot_b = {bus.rot_I[0], bus.rot_I[1], bus.rot_I[2], bus.rot_I[3]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v, input int k);
        logic [7:0] t;
        t = {v, v} << (k % 4);
        return t[7:4];
    endfunction

    function automatic logic [3:0] rotr(input logic [3:0] v, input int k);
        logic [7:0] t;
        t = {v, v} >> (k % 4);
        return t[3:0];
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [3:0] model(input logic [3:0] d, input logic [1:0] op, input logic [1:0] amt);
        case (op)
            2'b00:   return rotl(d, int'(amt));
            2'b01:   return rotr(d, int'(amt));
            2'b10:   return rev4(d);
            default: return rotl(rev4(d), int'(amt));
        endcase
    endfunction

    // Completed results are compared in order against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 32'(bus.out_data), 32'hx);
            else chk("result", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accept edge.
    task automatic send(input logic [3:0] d, input logic [1:0] op, input logic [1:0] amt);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_op    = op;
        bus.in_amt   = amt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                chk("accept_in_idle", 32'(bus.busy), 32'd0);
                exp_q.push_back(model(d, op, amt));
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                bus.in_data  = ~d;
                bus.in_op    = ~op;
                bus.in_amt   = ~amt;
                return;
            end
        end
        chk("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.in_op     = 2'd0;
        bus.in_amt    = 2'd0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_sel",       32'({bus.rot_x, bus.rot_y}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // rotate left 1: single STEP1 pass
        send(4'b1011, 2'b00, 2'd1);
        @(negedge clk);
        chk("rotl1_sel", 32'({bus.rot_x, bus.rot_y}), 32'b01);
        chk("rotl1_nvalid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("rotl1_valid", 32'(bus.out_valid), 32'd1);
        drain();

        // rotate right 1 = STEP2 then STEP1
        send(4'b1011, 2'b01, 2'd1);
        @(negedge clk);
        chk("rotr1_sel_a", 32'({bus.rot_x, bus.rot_y}), 32'b10);
        @(negedge clk);
        chk("rotr1_sel_b", 32'({bus.rot_x, bus.rot_y}), 32'b01);
        chk("rotr1_mid",   32'(bus.rot_I), 32'b1110);
        drain();

        send(4'b1011, 2'b10, 2'd3);
        @(negedge clk);
        chk("rev_sel", 32'({bus.rot_x, bus.rot_y}), 32'b11);
        drain();
        send(4'b1011, 2'b11, 2'd2);
        drain();

        // zero rotate with backpressure
        bus.out_ready = 1'b0;
        send(4'b1011, 2'b01, 2'd0);
        @(negedge clk);
        chk("zero_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0001;
        bus.in_op    = 2'b00;
        bus.in_amt   = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_data",  32'(bus.out_data),  32'b1011);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_nrdy",  32'(bus.in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_idle",  32'(bus.busy),      32'd0);
        chk("release_rdy",   32'(bus.in_ready),  32'd1);
        chk("release_nvld",  32'(bus.out_valid), 32'd0);
        chk("release_empty", 32'(exp_q.size()),  32'd0);
        @(posedge clk);
        #1;

        // reset in the middle of STEP2
        send(4'b1011, 2'b01, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",  32'(bus.busy),      32'd0);
        chk("mid_rst_data",  32'(bus.out_data),  32'd0);
        chk("mid_rst_rdy",   32'(bus.in_ready),  32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'b0110, 2'b01, 2'd3);
        drain();

        // back-to-back commands
        send(4'b1000, 2'b00, 2'd3);
        send(4'b0011, 2'b01, 2'd2);
        send(4'b1100, 2'b11, 2'd1);
        drain();
        for (int i = 0; i < 8; i++) begin
            logic [3:0] d;
            logic [1:0] op, amt;
            d   = 4'($urandom_range(0, 15));
            op  = 2'($urandom_range(0, 3));
            amt = 2'($urandom_range(0, 3));
            send(d, op, amt);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
